// File: rtl/conv_pkg.sv
// Shared definitions for the convolution line-buffer blocks.
package conv_pkg;

   localparam int PIXEL_W       = 8;
   localparam int IMAGE_MAX_W   = 64;
   localparam int LBN_LINES_MAX = 8;

   typedef logic [PIXEL_W-1:0]        pixel_t;
   typedef pixel_t [LBN_LINES_MAX-1:0] lbn_col_t;

   // Bank holding the line written k+1 lines before the one in bank wbank.
   function automatic int unsigned tap_bank(input int unsigned wbank,
                                            input int unsigned k,
                                            input int unsigned lines_n);
      return (wbank + 2 * lines_n - 1 - k) % lines_n;
   endfunction

endpackage

// File: rtl/generic_bram.sv
// Single-port block RAM with registered read; contents are never reset.
module generic_bram #(
   parameter int    WORD_W    = 8,
   parameter int    WORDS_N   = 64,
   parameter int    ADDR_W    = 6,
   parameter bit    HOLD_DOUT = 1'b1,
   parameter string COLLISION = "DEFER_WRITE"
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] dout
);

   logic [WORD_W-1:0] mem [WORDS_N];

   always_ff @(posedge clk) begin
      if (en) begin
         // DEFER_WRITE returns the old word when reading the slot being written.
         if (we && (COLLISION != "DEFER_WRITE"))
            dout <= din;
         else
            dout <= mem[addr];
         if (we)
            mem[addr] <= din;
      end else if (!HOLD_DOUT) begin
         dout <= '0;
      end
   end

endmodule

// File: rtl/conv_cntrl_lbn_fpga.sv
// Line buffer: delivers a vertical column of the previous LINES_N lines per pushed pixel.
module conv_cntrl_lbn_fpga #(
   parameter int PIXEL_W     = conv_pkg::PIXEL_W,
   parameter int IMAGE_MAX_W = conv_pkg::IMAGE_MAX_W,
   parameter int LINES_N     = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push_i,
   input  logic [PIXEL_W-1:0]              dat_i,
   input  logic                            sof_i,
   input  logic                            eol_i,
   output logic [LINES_N-1:0][PIXEL_W-1:0] col_o,
   output logic [LINES_N-1:0]              tap_vld_o,
   output logic                            col_vld_o,
   output logic                            ovf_o
);

   import conv_pkg::*;

   localparam int AW = (IMAGE_MAX_W > 1) ? $clog2(IMAGE_MAX_W) : 1;
   localparam int BW = (LINES_N > 1) ? $clog2(LINES_N) : 1;
   localparam logic [AW-1:0] ADDR_LAST = AW'(IMAGE_MAX_W - 1);

   logic [AW-1:0] addr_r, waddr, addr_nxt;
   logic [BW-1:0] wbank, wbank_eff, wbank_nxt;
   logic [3:0]    lines_done, lines_eff, lines_nxt;
   logic          sat_r, ovf_evt, wr;

   logic [LINES_N-1:0][PIXEL_W-1:0] rd_dat;

   logic               vld_p0, sof_p0, ovf_p0;
   logic [LINES_N-1:0] tap_p0;
   logic [BW-1:0]      sel_p0 [LINES_N];

   // A push with sof behaves as if the counters were already cleared.
   always_comb begin
      wr        = push_i & ~rst;
      waddr     = sof_i ? '0 : addr_r;
      wbank_eff = sof_i ? '0 : wbank;
      lines_eff = sof_i ? '0 : lines_done;
      if (eol_i)
         addr_nxt = '0;
      else if (waddr == ADDR_LAST)
         addr_nxt = waddr;
      else
         addr_nxt = waddr + 1'b1;
      if (eol_i)
         wbank_nxt = (wbank_eff == BW'(LINES_N - 1)) ? '0 : wbank_eff + 1'b1;
      else
         wbank_nxt = wbank_eff;
      lines_nxt = (eol_i && (lines_eff < 4'(LINES_N))) ? lines_eff + 1'b1 : lines_eff;
      ovf_evt   = push_i & ~sof_i & sat_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r     <= '0;
         wbank      <= '0;
         lines_done <= '0;
         sat_r      <= 1'b0;
      end else if (push_i) begin
         addr_r     <= addr_nxt;
         wbank      <= wbank_nxt;
         lines_done <= lines_nxt;
         sat_r      <= ~eol_i & (waddr == ADDR_LAST);
      end
   end

   for (genvar b = 0; b < LINES_N; b++) begin : g_bank
      generic_bram #(
         .WORD_W    (PIXEL_W),
         .WORDS_N   (IMAGE_MAX_W),
         .ADDR_W    (AW),
         .HOLD_DOUT (1'b1),
         .COLLISION ("DEFER_WRITE")
      ) u_bram (
         .clk  (clk),
         .en   (wr),
         .we   (wr && (wbank_eff == BW'(b))),
         .addr (waddr),
         .din  (dat_i),
         .dout (rd_dat[b])
      );
   end

   // Stage p0: BRAM read in flight; bank mapping and tap validity travel with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         sof_p0 <= 1'b0;
         ovf_p0 <= 1'b0;
         tap_p0 <= '0;
         for (int k = 0; k < LINES_N; k++) sel_p0[k] <= '0;
      end else begin
         vld_p0 <= push_i;
         sof_p0 <= push_i & sof_i;
         ovf_p0 <= ovf_evt;
         if (push_i) begin
            for (int k = 0; k < LINES_N; k++) begin
               tap_p0[k] <= (32'(lines_eff) > k);
               sel_p0[k] <= BW'(tap_bank(32'(wbank_eff), k, LINES_N));
            end
         end
      end
   end

   // Stage p1: output register, holds while no new column arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_vld_o <= 1'b0;
         tap_vld_o <= '0;
         col_o     <= '0;
         ovf_o     <= 1'b0;
      end else begin
         col_vld_o <= vld_p0;
         ovf_o     <= (ovf_o & ~sof_p0) | ovf_p0;
         if (vld_p0) begin
            tap_vld_o <= tap_p0;
            for (int k = 0; k < LINES_N; k++) col_o[k] <= rd_dat[sel_p0[k]];
         end
      end
   end

endmodule
